alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the team's fixed 4-bit registered adder.
- Executes one of eight operations on two WIDTH-bit register-file operands.
- Single-cycle ops: add, sub, and, or, xor, shl, shr. Multi-cycle op: unsigned shift-add multiply.
- Results and status flags are registered. The block sits between the register-file read ports and the writeback stage, using a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2); the bench also runs WIDTH=4.
- SHW, $clog2(WIDTH), number of low rd_reg2 bits used as the shift amount (derived, not overridden).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_reg1  in  WIDTH  operand A.
- rd_reg2  in  WIDTH  operand B / shift amount.
- op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
- enable_op  in  1  start request; sampled only when busy=0.
- busy  out  1  high while a MUL is iterating.
- done  out  1  one-cycle pulse marking new ans/ans_hi/flags.
- ans  out  WIDTH  result (MUL: low half of product).
- ans_hi  out  WIDTH  MUL: high half of product; 0 for all other ops.
- flag_z  out  1  zero.
- flag_c  out  1  carry/borrow.
- flag_v  out  1  signed overflow.
- flag_n  out  1  negative.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n=0: FSM=IDLE; busy, done, ans, ans_hi and all flags =0; MUL accumulator and counter cleared.
- Reset mid-MUL aborts the operation. No done pulse is produced.
- FSM states:
  - IDLE: enable_op=1 at a rising edge accepts op, rd_reg1 and rd_reg2 at that edge.
    - Non-MUL ops: outputs update at the accept edge (latency 1); done=1 for the following cycle; FSM stays in IDLE.
    - MUL: operands are latched, busy=1, counter=0, FSM goes to MUL_RUN; done stays 0.
  - MUL_RUN: one shift-add iteration per edge (multiplier LSB-first, 2*WIDTH-bit accumulator).
    - At the WIDTH-th edge after accept: ans/ans_hi/flags are written, done=1, busy=0, FSM returns to IDLE.
    - done is therefore visible WIDTH cycles after the accept edge.
- enable_op while busy=1 is ignored: no queueing, no effect on the running MUL. A request in the same cycle that busy falls is also ignored; the next request is accepted on the following edge.
- Back-to-back single-cycle ops are accepted on consecutive edges; done stays high continuously.
- Between operations, ans/ans_hi/flags hold their last values. done is 0 whenever no result was written that edge.
- Arithmetic is modulo 2^WIDTH.
- ADD: c = carry-out; v = (A[msb]==B[msb]) && (R[msb]!=A[msb]).
- SUB: R = A−B; c = borrow (A<B unsigned); v = (A[msb]!=B[msb]) && (R[msb]!=A[msb]).
- AND/OR/XOR: c=0, v=0.
- SHL/SHR: logical shifts by rd_reg2[SHW-1:0]; upper bits of rd_reg2 are ignored. Shift by 0 passes A unchanged. c=0, v=0.
- MUL: unsigned; {ans_hi,ans} = A*B; z = (full product==0); c = (ans_hi!=0); v=0; n = ans_hi[msb].
- All non-MUL ops: z = (R==0); n = R[msb]; ans_hi=0.
- All flags are written together with ans on every completed op.

Test Plan:
- WIDTH=4, ADD 4'hF+4'h1 → after one edge: ans=0, z=1, c=1, v=0, n=0, done=1 for exactly one cycle.
- WIDTH=4, ADD 4'h7+4'h1 → ans=4'h8, v=1, n=1, c=0. Then SUB 4'h3−4'h5 on the next edge → ans=4'hE, c=1, n=1, v=0; done high for two consecutive cycles.
- WIDTH=8, SHL A=8'h81, B=8'hF9 (amount 1) → ans=8'h02. SHR A=8'h80, B=8'h07 → ans=8'h01. SHL by B=8'h00 → ans=A.
- WIDTH=4, MUL 4'hF×4'hF → busy=1 for 4 cycles; done 4 cycles after accept with ans_hi=4'hE, ans=4'h1, c=1, n=1, z=0. A MUL 4'h0×4'h9 gives z=1.
- WIDTH=8, MUL 8'h12×8'h34 with enable_op held high and op=ADD pulsed during busy → product 16'h03A8 delivered, the ADD is ignored, exactly one done pulse.
- WIDTH=8: assert rst_n=0 asynchronously mid-MUL (between edges) → busy/done/ans/flags go to 0 immediately with no done pulse. After release, ADD 8'h01+8'h01 → ans=8'h02.

Source files
------------

// File: rtl/alu_seq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | alu_seq : registered 8-op ALU, single-cycle ops plus shift-add multiply |
// | Revision 1.0                                                            |
// +------------------------------------------------------------------------+
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] rd_reg1,
  input  logic [WIDTH-1:0] rd_reg2,
  input  logic [2:0]       op,
  input  logic             enable_op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ans,
  output logic [WIDTH-1:0] ans_hi,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_n
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_MUL_RUN = 1'b1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  logic [0:0]         state_q,  state_d;
  logic               done_q,   done_d;
  logic [WIDTH-1:0]   ans_q,    ans_d;
  logic [WIDTH-1:0]   ans_hi_q, ans_hi_d;
  logic               z_q, z_d, c_q, c_d, v_q, v_d, n_q, n_d;
  logic [2*WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q,    acc_d;
  logic [CW-1:0]      cnt_q,    cnt_d;

  logic [WIDTH:0]     sum_w;
  logic [WIDTH:0]     diff_w;
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   alu_r;
  logic               alu_c;
  logic               alu_v;
  logic [2*WIDTH-1:0] acc_step;

  assign shamt = rd_reg2[SHW-1:0];

  // Single-cycle datapath; the extra top bit of sum/diff is carry / borrow.
  always_comb begin
    sum_w  = {1'b0, rd_reg1} + {1'b0, rd_reg2};
    diff_w = {1'b0, rd_reg1} - {1'b0, rd_reg2};
    alu_r  = '0;
    alu_c  = 1'b0;
    alu_v  = 1'b0;
    case (op)
      OP_ADD: begin
        alu_r = sum_w[WIDTH-1:0];
        alu_c = sum_w[WIDTH];
        alu_v = (rd_reg1[WIDTH-1] == rd_reg2[WIDTH-1]) &&
                (sum_w[WIDTH-1] != rd_reg1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_r = diff_w[WIDTH-1:0];
        alu_c = diff_w[WIDTH];
        alu_v = (rd_reg1[WIDTH-1] != rd_reg2[WIDTH-1]) &&
                (diff_w[WIDTH-1] != rd_reg1[WIDTH-1]);
      end
      OP_AND:  alu_r = rd_reg1 & rd_reg2;
      OP_OR:   alu_r = rd_reg1 | rd_reg2;
      OP_XOR:  alu_r = rd_reg1 ^ rd_reg2;
      OP_SHL:  alu_r = rd_reg1 << shamt;
      OP_SHR:  alu_r = rd_reg1 >> shamt;
      default: alu_r = '0;
    endcase
  end

  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    ans_d    = ans_q;
    ans_hi_d = ans_hi_q;
    z_d      = z_q;
    c_d      = c_q;
    v_d      = v_q;
    n_d      = n_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (enable_op) begin
          if (op == OP_MUL) begin
            mcand_d  = {{WIDTH{1'b0}}, rd_reg1};
            mplier_d = rd_reg2;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_MUL_RUN;
          end else begin
            ans_d    = alu_r;
            ans_hi_d = '0;
            z_d      = (alu_r == '0);
            c_d      = alu_c;
            v_d      = alu_v;
            n_d      = alu_r[WIDTH-1];
            done_d   = 1'b1;
          end
        end
      end
      S_MUL_RUN: begin
        // Multiplier consumed LSB-first while the multiplicand walks left.
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          ans_d    = acc_step[WIDTH-1:0];
          ans_hi_d = acc_step[2*WIDTH-1:WIDTH];
          z_d      = (acc_step == '0);
          c_d      = (acc_step[2*WIDTH-1:WIDTH] != '0);
          v_d      = 1'b0;
          n_d      = acc_step[2*WIDTH-1];
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      done_q   <= 1'b0;
      ans_q    <= '0;
      ans_hi_q <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      n_q      <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      ans_q    <= ans_d;
      ans_hi_q <= ans_hi_d;
      z_q      <= z_d;
      c_q      <= c_d;
      v_q      <= v_d;
      n_q      <= n_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy   = (state_q == S_MUL_RUN);
  assign done   = done_q;
  assign ans    = ans_q;
  assign ans_hi = ans_hi_q;
  assign flag_z = z_q;
  assign flag_c = c_q;
  assign flag_v = v_q;
  assign flag_n = n_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// Bench for alu_seq: drives a WIDTH=4 and a WIDTH=8 instance from tables,
// hand sequences and random ops checked against an arithmetic model.
module tb_alu_seq;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3;
  localparam logic [2:0] XOR_ = 3'd4, SHL = 3'd5, SHR = 3'd6, MUL = 3'd7;

  typedef struct packed {
    logic [7:0] hi;
    logic [7:0] lo;
    logic z, c, v, n;
  } res_t;

  typedef struct {
    int         w;
    logic [2:0] o;
    logic [7:0] a, b;
    res_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0] a4, b4, ans4, hi4;
  logic [2:0] op4;
  logic en4, busy4, done4, z4, c4, v4, n4;
  logic [7:0] a8, b8, ans8, hi8;
  logic [2:0] op8;
  logic en8, busy8, done8, z8, c8, v8, n8;

  alu_seq #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .rd_reg1(a4), .rd_reg2(b4), .op(op4),
    .enable_op(en4), .busy(busy4), .done(done4), .ans(ans4), .ans_hi(hi4),
    .flag_z(z4), .flag_c(c4), .flag_v(v4), .flag_n(n4));

  alu_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .rd_reg1(a8), .rd_reg2(b8), .op(op8),
    .enable_op(en8), .busy(busy8), .done(done8), .ans(ans8), .ans_hi(hi8),
    .flag_z(z8), .flag_c(c8), .flag_v(v8), .flag_n(n8));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_res(input string name, input res_t got, input res_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got hi=%h lo=%h zcvn=%b%b%b%b expected hi=%h lo=%h zcvn=%b%b%b%b",
               name, got.hi, got.lo, got.z, got.c, got.v, got.n,
               exp.hi, exp.lo, exp.z, exp.c, exp.v, exp.n);
    end
  endtask

  function automatic res_t mkres(input logic [7:0] hi, lo, input bit z, c, v, n);
    res_t r;
    r.hi = hi; r.lo = lo; r.z = z; r.c = c; r.v = v; r.n = n;
    return r;
  endfunction

  function automatic vec_t mk(input int w, input logic [2:0] o, input logic [7:0] a, b,
                              input logic [7:0] hi, lo, input bit z, c, v, n);
    vec_t t;
    t.w = w; t.o = o; t.a = a; t.b = b; t.exp = mkres(hi, lo, z, c, v, n);
    return t;
  endfunction

  // Reference: plain integer arithmetic on the operation definitions.
  function automatic res_t model(input int w, input logic [2:0] o, input logic [7:0] a, b);
    int unsigned mask, au, bu, lo, hi, p, sh;
    int msb;
    res_t e;
    mask = (32'd1 << w) - 1;
    au = a & mask; bu = b & mask; msb = w - 1;
    sh = bu % w;
    lo = 0; hi = 0;
    e = '0;
    case (o)
      ADD: begin
        p = au + bu; lo = p & mask; e.c = (p > mask);
        e.v = (((au >> msb) & 1) == ((bu >> msb) & 1)) && (((lo >> msb) & 1) != ((au >> msb) & 1));
      end
      SUB: begin
        lo = (au - bu) & mask; e.c = (au < bu);
        e.v = (((au >> msb) & 1) != ((bu >> msb) & 1)) && (((lo >> msb) & 1) != ((au >> msb) & 1));
      end
      AND_: lo = au & bu;
      OR_:  lo = au | bu;
      XOR_: lo = au ^ bu;
      SHL:  lo = (au << sh) & mask;
      SHR:  lo = au >> sh;
      default: begin
        p = au * bu; lo = p & mask; hi = p >> w;
      end
    endcase
    e.lo = lo[7:0];
    e.hi = hi[7:0];
    if (o == MUL) begin
      e.z = (lo == 0) && (hi == 0);
      e.c = (hi != 0);
      e.n = ((hi >> msb) & 1) != 0;
    end else begin
      e.z = (lo == 0);
      e.n = ((lo >> msb) & 1) != 0;
    end
    return e;
  endfunction

  task automatic drive(input int w, input bit en, input logic [2:0] o, input logic [7:0] a, b);
    if (w == 4) begin
      en4 = en; op4 = o; a4 = a[3:0]; b4 = b[3:0];
    end else begin
      en8 = en; op8 = o; a8 = a; b8 = b;
    end
  endtask

  function automatic res_t get_res(input int w);
    if (w == 4) return mkres({4'h0, hi4}, {4'h0, ans4}, z4, c4, v4, n4);
    return mkres(hi8, ans8, z8, c8, v8, n8);
  endfunction

  function automatic bit get_done(input int w);
    return (w == 4) ? done4 : done8;
  endfunction

  function automatic bit get_busy(input int w);
    return (w == 4) ? busy4 : busy8;
  endfunction

  // lat counts edges after the accept edge until done is seen (bounded).
  task automatic run_op(input int w, input logic [2:0] o, input logic [7:0] a, b,
                        output res_t r, output int lat, output int busy_cyc);
    @(negedge clk);
    drive(w, 1'b1, o, a, b);
    @(posedge clk); #1;
    drive(w, 1'b0, o, a, b);
    lat = 0; busy_cyc = 0;
    while (!get_done(w) && lat < 4 * w) begin
      if (get_busy(w)) busy_cyc++;
      @(posedge clk); #1;
      lat++;
    end
    r = get_res(w);
  endtask

  task automatic run_and_check(input string tag, input int w, input logic [2:0] o,
                               input logic [7:0] a, b, input res_t exp);
    res_t r;
    int lat, bc;
    run_op(w, o, a, b, r, lat, bc);
    chk_res({tag, " result"}, r, exp);
    chk({tag, " latency"}, lat, (o == MUL) ? w : 0);
    if (o == MUL) chk({tag, " busy cycles"}, bc, w);
    @(posedge clk); #1;
    chk({tag, " done single pulse"}, int'(get_done(w)), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[$];
    res_t r, cap;
    int ndone, done_at, late_done;

    rst_n = 1'b0;
    drive(4, 1'b0, ADD, 8'h0, 8'h0);
    drive(8, 1'b0, ADD, 8'h0, 8'h0);

    vt.push_back(mk(4, ADD, 8'h0F, 8'h01, 8'h00, 8'h00, 1, 1, 0, 0));
    vt.push_back(mk(4, ADD, 8'h07, 8'h01, 8'h00, 8'h08, 0, 0, 1, 1));
    vt.push_back(mk(4, SUB, 8'h03, 8'h05, 8'h00, 8'h0E, 0, 1, 0, 1));
    vt.push_back(mk(4, MUL, 8'h0F, 8'h0F, 8'h0E, 8'h01, 0, 1, 0, 1));
    vt.push_back(mk(4, MUL, 8'h00, 8'h09, 8'h00, 8'h00, 1, 0, 0, 0));
    vt.push_back(mk(8, SHL, 8'h81, 8'hF9, 8'h00, 8'h02, 0, 0, 0, 0));
    vt.push_back(mk(8, SHR, 8'h80, 8'h07, 8'h00, 8'h01, 0, 0, 0, 0));
    vt.push_back(mk(8, SHL, 8'hA5, 8'h00, 8'h00, 8'hA5, 0, 0, 0, 1));
    vt.push_back(mk(8, SUB, 8'h80, 8'h01, 8'h00, 8'h7F, 0, 0, 1, 0));
    vt.push_back(mk(8, AND_, 8'hF0, 8'h3C, 8'h00, 8'h30, 0, 0, 0, 0));
    vt.push_back(mk(8, OR_, 8'hF0, 8'h0C, 8'h00, 8'hFC, 0, 0, 0, 1));
    vt.push_back(mk(8, XOR_, 8'h5A, 8'h5A, 8'h00, 8'h00, 1, 0, 0, 0));
    vt.push_back(mk(8, MUL, 8'h12, 8'h34, 8'h03, 8'hA8, 0, 1, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    chk_res("reset w4 outputs", get_res(4), '0);
    chk_res("reset w8 outputs", get_res(8), '0);
    chk("reset busy/done", {busy4, done4, busy8, done8}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) run_and_check($sformatf("vec%0d", i), vt[i].w, vt[i].o, vt[i].a, vt[i].b, vt[i].exp);

    // Back-to-back single-cycle ops on consecutive edges.
    @(negedge clk); drive(4, 1'b1, ADD, 8'h07, 8'h01);
    @(posedge clk); #1;
    chk_res("b2b add", get_res(4), mkres(8'h00, 8'h08, 0, 0, 1, 1));
    chk("b2b done1", int'(done4), 1);
    @(negedge clk); drive(4, 1'b1, SUB, 8'h03, 8'h05);
    @(posedge clk); #1;
    drive(4, 1'b0, SUB, 8'h03, 8'h05);
    chk_res("b2b sub", get_res(4), mkres(8'h00, 8'h0E, 0, 1, 0, 1));
    chk("b2b done2", int'(done4), 1);
    @(posedge clk); #1;
    chk("b2b done drop", int'(done4), 0);

    // MUL with enable held high and an ADD presented while busy.
    @(negedge clk); drive(8, 1'b1, MUL, 8'h12, 8'h34);
    @(posedge clk); #1;
    chk("held busy after accept", int'(busy8), 1);
    drive(8, 1'b1, ADD, 8'h01, 8'h01);
    ndone = 0; done_at = -1; cap = '0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      if (done8) begin
        ndone++;
        if (done_at < 0) begin
          done_at = k;
          cap = get_res(8);
        end
        drive(8, 1'b0, ADD, 8'h01, 8'h01);
      end
    end
    chk("held done count", ndone, 1);
    chk("held done position", done_at, 7);
    chk_res("held product", cap, mkres(8'h03, 8'hA8, 0, 1, 0, 0));

    // Asynchronous reset between edges during a MUL.
    @(negedge clk); drive(8, 1'b1, MUL, 8'hFF, 8'hFF);
    @(posedge clk); #1;
    drive(8, 1'b0, MUL, 8'hFF, 8'hFF);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk_res("async reset outputs", get_res(8), '0);
    chk("async reset busy/done", {busy8, done8}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    late_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (done8 || busy8) late_done++;
    end
    chk("no done after abort", late_done, 0);
    run_and_check("post-reset add", 8, ADD, 8'h01, 8'h01, mkres(8'h00, 8'h02, 0, 0, 0, 0));

    // Random ops on both widths against the model.
    for (int i = 0; i < 60; i++) begin
      int w;
      logic [2:0] o;
      logic [7:0] a, b;
      w = (i % 2 == 0) ? 4 : 8;
      o = 3'($urandom_range(0, 7));
      a = 8'($urandom);
      b = 8'($urandom);
      run_and_check($sformatf("rand%0d w%0d op%0d a%h b%h", i, w, o, a, b), w, o, a, b, model(w, o, a, b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
